// File: rtl/addsub_pkg.sv
// Shared encodings for the round-robin add/sub scheduler: FSM states and operation modes.
package addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam logic M_ADD = 1'b0;
    localparam logic M_SUB = 1'b1;

endpackage

// File: rtl/add_sub.sv
// Ripple-carry add/subtract built from full adders. Subtract is A + ~B + 1 with the mode bit as carry-in.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_sub
    import addsub_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         m,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         ovf
);
    logic [N-1:0] bx;
    logic [N:0]   c;

    assign bx   = (m == M_SUB) ? ~b : b;
    assign c[0] = (m == M_SUB);

    for (genvar i = 0; i < N; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (bx[i]),
            .ci (c[i]),
            .s  (result[i]),
            .co (c[i+1])
        );
    end

    assign carry = c[N];
    // Overflow when both effective operands share a sign that the result does not.
    assign ovf   = (a[N-1] == bx[N-1]) & (result[N-1] != a[N-1]);
endmodule

// File: rtl/addsub_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above ptr, wrapping around.
module addsub_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);
    logic found;
    int   j;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && req_valid[IDW'(j)]) begin
                found              = 1'b1;
                grant[IDW'(j)]     = 1'b1;
                grant_idx          = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/addsub_rr_sched.sv
// Shares one add/sub datapath between NREQ requesters: round-robin accept, one-cycle execute, held response.
module addsub_rr_sched
    import addsub_pkg::*;
#(
    parameter  int N    = 4,
    parameter  int NREQ = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_valid,
    output logic [NREQ-1:0] req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0] req_m,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [N-1:0]    rsp_result,
    output logic            rsp_carry,
    output logic            rsp_ovf,
    output logic [IDW-1:0]  rsp_id
);
    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, id_q, grant_idx;
    logic [NREQ-1:0] grant;
    logic [N-1:0]    a_q, b_q, sel_a, sel_b, sum;
    logic            m_q, sel_m, sum_c, sum_o;
    logic            accept;

    addsub_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_valid (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    add_sub #(.N(N)) u_add_sub (
        .a      (a_q),
        .b      (b_q),
        .m      (m_q),
        .result (sum),
        .carry  (sum_c),
        .ovf    (sum_o)
    );

    assign accept = (state_q == ST_IDLE) & (|grant);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = accept ? ST_EXEC : ST_IDLE;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: state_d = (rsp_valid & rsp_ready) ? ST_IDLE : ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_IDLE) ? grant : '0;
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_m = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a = req_a[i*N +: N];
                sel_b = req_b[i*N +: N];
                sel_m = req_m[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= 1'b0;
            id_q  <= '0;
            ptr_q <= '0;
        end else if (accept) begin
            a_q   <= sel_a;
            b_q   <= sel_b;
            m_q   <= sel_m;
            id_q  <= grant_idx;
            ptr_q <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // rsp_valid falls on handshake and in any state other than EXEC/RESP, including illegal ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_id     <= '0;
        end else begin
            rsp_valid <= (state_q == ST_EXEC) | ((state_q == ST_RESP) & rsp_valid & ~rsp_ready);
            if (state_q == ST_EXEC) begin
                rsp_result <= sum;
                rsp_carry  <= sum_c;
                rsp_ovf    <= sum_o;
                rsp_id     <= id_q;
            end
        end
    end
endmodule

// File: tb/tb_addsub_rr_sched.sv
// Bench for addsub_rr_sched: directed scenarios plus random traffic against an arithmetic/round-robin model.
module tb_addsub_rr_sched;
    localparam int N = 4, NREQ = 4, IDW = 2;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [NREQ-1:0] req_valid, req_ready, req_m;
    logic [NREQ*N-1:0] req_a, req_b;
    logic rsp_valid, rsp_ready, rsp_carry, rsp_ovf;
    logic [N-1:0] rsp_result;
    logic [IDW-1:0] rsp_id;

    int checks = 0, errors = 0, mp = 0, cyc = 0;
    logic [N-1:0] oa[NREQ], ob[NREQ];
    logic [NREQ-1:0] va = '0, om = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    addsub_rr_sched #(.N(N), .NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_m(req_m), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_carry(rsp_carry),
        .rsp_ovf(rsp_ovf), .rsp_id(rsp_id)
    );

    // ---------------- model ----------------
    function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Expected {result, carry, ovf, id} from plain integer arithmetic.
    function automatic logic [N+IDW+1:0] model_rsp(input logic [N-1:0] a, b, input logic m, input int id);
        int ua, ub, sa, sb, full, sres;
        logic c, o;
        logic [N-1:0] r;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        if (m) begin
            full = ua - ub; sres = sa - sb; c = (ua >= ub);
        end else begin
            full = ua + ub; sres = sa + sb; c = (full > 15);
        end
        r = N'(full);
        o = (sres > 7) || (sres < -8);
        return {r, c, o, IDW'(id)};
    endfunction

    // ---------------- drivers ----------------
    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = oa[i];
            req_b[i*N +: N] = ob[i];
        end
        req_valid = va;
        req_m     = om;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        va = '0;
        drive_reqs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mp = 0;
    endtask

    // One lockstep op from IDLE: sample grant, execute, capture response, return to IDLE.
    task automatic serve(output logic [NREQ-1:0] rdy_idle, output logic vld_exec, vld_resp,
                         output logic [N+IDW+1:0] rsp);
        drive_reqs();
        #1;
        rdy_idle = req_ready;
        @(negedge clk);
        va = va & ~rdy_idle;
        drive_reqs();
        #1;
        vld_exec = rsp_valid | (|req_ready);
        @(negedge clk);
        vld_resp = rsp_valid;
        rsp = {rsp_result, rsp_carry, rsp_ovf, rsp_id};
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        va = '0;
        for (int i = 0; i < NREQ; i++) begin oa[i] = '0; ob[i] = '0; end
        rsp_ready = 1'b1;
        do_reset();
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_id} !== '0) begin
            errors++;
            $display("FAIL reset_idle got rdy=%b vld=%b r=%h c=%b o=%b id=%0d want all zero",
                     req_ready, rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_id);
        end
        oa[1] = 4'd6; ob[1] = 4'd7; om[1] = 1'b0; va = 4'b0010; rsp_ready = 1'b0;
        drive_reqs();
        @(negedge clk);
        va = '0;
        drive_reqs();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_resp rsp_valid=%b want 1", rsp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_id} !== '0) begin
            errors++;
            $display("FAIL reset_async got vld=%b r=%h c=%b o=%b id=%0d want all zero",
                     rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        mp = 0;
    endtask

    task automatic test_add();
        int a_t[2] = '{3, 7};
        int b_t[2] = '{5, 9};
        logic [NREQ-1:0] rdy;
        logic ve, vr;
        logic [N+IDW+1:0] got, exp;
        int g;
        for (int k = 0; k < 2; k++) begin
            oa[0] = N'(a_t[k]); ob[0] = N'(b_t[k]); om[0] = 1'b0; va[0] = 1'b1;
            g = model_grant(va, mp);
            exp = model_rsp(oa[0], ob[0], 1'b0, g);
            serve(rdy, ve, vr, got);
            mp = (g + 1) % NREQ;
            checks++;
            if (rdy !== onehot(g)) begin errors++; $display("FAIL add_grant got %b want %b", rdy, onehot(g)); end
            checks++;
            if ({ve, vr} !== 2'b01) begin errors++; $display("FAIL add_latency got exec/resp=%b want 01", {ve, vr}); end
            checks++;
            if (got !== exp) begin errors++; $display("FAIL add_rsp got %h want %h", got, exp); end
        end
    endtask

    task automatic test_sub();
        int a_t[3] = '{2, 5, 8};
        int b_t[3] = '{5, 2, 1};
        logic [NREQ-1:0] rdy;
        logic ve, vr;
        logic [N+IDW+1:0] got, exp;
        int g;
        for (int k = 0; k < 3; k++) begin
            oa[2] = N'(a_t[k]); ob[2] = N'(b_t[k]); om[2] = 1'b1; va[2] = 1'b1;
            g = model_grant(va, mp);
            exp = model_rsp(oa[2], ob[2], 1'b1, g);
            serve(rdy, ve, vr, got);
            mp = (g + 1) % NREQ;
            checks++;
            if (rdy !== onehot(g)) begin errors++; $display("FAIL sub_grant got %b want %b", rdy, onehot(g)); end
            checks++;
            if ({ve, vr} !== 2'b01) begin errors++; $display("FAIL sub_latency got exec/resp=%b want 01", {ve, vr}); end
            checks++;
            if (got !== exp) begin errors++; $display("FAIL sub_rsp got %h want %h", got, exp); end
        end
    endtask

    task automatic test_round_robin();
        int g, last, now;
        bit got;
        logic [N+IDW+1:0] exp;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            oa[i] = N'(3 * i + 1); ob[i] = N'(i + 5); om[i] = i[0];
        end
        va = '1;
        drive_reqs();
        last = 0;
        for (int n = 0; n < 5; n++) begin
            got = 0;
            for (int t = 0; t < 12 && !got; t++) begin
                @(negedge clk);
                if (rsp_valid) got = 1;
            end
            now = cyc;
            g = model_grant(4'b1111, mp);
            mp = (g + 1) % NREQ;
            exp = model_rsp(oa[g], ob[g], om[g], g);
            checks++;
            if (!got) begin
                errors++;
                $display("FAIL rr_timeout response %0d never arrived", n);
            end else if ({rsp_result, rsp_carry, rsp_ovf, rsp_id} !== exp) begin
                errors++;
                $display("FAIL rr_rsp n=%0d got %h want %h", n, {rsp_result, rsp_carry, rsp_ovf, rsp_id}, exp);
            end
            if (n > 0) begin
                checks++;
                if (now - last != 3) begin errors++; $display("FAIL rr_spacing got %0d want 3", now - last); end
            end
            last = now;
        end
        va = '0;
        drive_reqs();
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [N+IDW+1:0] snap, exp;
        bit got;
        int g;
        oa[1] = 4'd9; ob[1] = 4'd12; om[1] = 1'b1; va = 4'b0010; rsp_ready = 1'b0;
        g = model_grant(va, mp);
        exp = model_rsp(oa[1], ob[1], 1'b1, g);
        mp = (g + 1) % NREQ;
        drive_reqs();
        @(negedge clk);
        va = 4'b1101;
        drive_reqs();
        got = 0;
        for (int t = 0; t < 6 && !got; t++) begin
            @(negedge clk);
            if (rsp_valid) got = 1;
        end
        snap = {rsp_result, rsp_carry, rsp_ovf, rsp_id};
        checks++;
        if (!got || snap !== exp) begin
            errors++;
            $display("FAIL bp_rsp got valid=%b data=%h want 1 %h", got, snap, exp);
        end
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_id, req_ready} !== {1'b1, exp, 4'b0000}) begin
                errors++;
                $display("FAIL bp_hold t=%0d got vld=%b data=%h rdy=%b want 1 %h 0000", t, rsp_valid,
                         {rsp_result, rsp_carry, rsp_ovf, rsp_id}, req_ready, exp);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_result, rsp_carry, rsp_ovf, rsp_id} !== {1'b0, exp}) begin
            errors++;
            $display("FAIL bp_release got vld=%b data=%h want 0 %h", rsp_valid,
                     {rsp_result, rsp_carry, rsp_ovf, rsp_id}, exp);
        end
        checks++;
        if (req_ready !== onehot(model_grant(va, mp))) begin
            errors++;
            $display("FAIL bp_idle_grant got %b want %b", req_ready, onehot(model_grant(va, mp)));
        end
        va = '0;
        drive_reqs();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_single got rsp_valid=%b want 0", rsp_valid); end
    endtask

    task automatic test_ptr();
        logic [NREQ-1:0] rdy;
        logic ve, vr;
        logic [N+IDW+1:0] got, exp;
        int g;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin oa[i] = N'(i + 2); ob[i] = N'(11 - i); om[i] = 1'b0; end
        va = 4'b0010;
        for (int s = 0; s < 3; s++) begin
            if (s == 1) va = 4'b1001;
            g = model_grant(va, mp);
            exp = model_rsp(oa[g], ob[g], om[g], g);
            serve(rdy, ve, vr, got);
            mp = (g + 1) % NREQ;
            checks++;
            if (rdy !== onehot(g) || got !== exp) begin
                errors++;
                $display("FAIL ptr_seq s=%0d got rdy=%b rsp=%h want %b %h", s, rdy, got, onehot(g), exp);
            end
        end
        va = 4'b0010;
        drive_reqs();
        #1;
        checks++;
        if (req_ready !== onehot(model_grant(va, mp))) begin
            errors++;
            $display("FAIL ptr_pre_reset got %b want %b", req_ready, onehot(model_grant(va, mp)));
        end
        @(negedge clk);
        va = '0;
        drive_reqs();
        rst_n = 1'b0;
        mp = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ptr_discard t=%0d rsp_valid=%b want 0", t, rsp_valid); end
        end
        va = 4'b0101;
        g = model_grant(va, mp);
        exp = model_rsp(oa[g], ob[g], om[g], g);
        serve(rdy, ve, vr, got);
        mp = (g + 1) % NREQ;
        checks++;
        if (rdy !== onehot(g) || got !== exp) begin
            errors++;
            $display("FAIL ptr_after_reset got rdy=%b rsp=%h want %b %h", rdy, got, onehot(g), exp);
        end
        va = '0;
        drive_reqs();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] rdy;
        logic ve, vr;
        logic [N+IDW+1:0] got, exp;
        int g;
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!va[i] && $urandom_range(0, 2) == 0) begin
                    oa[i] = N'($urandom_range(0, 15));
                    ob[i] = N'($urandom_range(0, 15));
                    om[i] = 1'($urandom_range(0, 1));
                    va[i] = 1'b1;
                end
            end
            g = model_grant(va, mp);
            if (g < 0) begin
                drive_reqs();
                #1;
                checks++;
                if (req_ready !== '0) begin errors++; $display("FAIL rand_idle got %b want 0000", req_ready); end
                @(negedge clk);
            end else begin
                exp = model_rsp(oa[g], ob[g], om[g], g);
                serve(rdy, ve, vr, got);
                mp = (g + 1) % NREQ;
                checks++;
                if (rdy !== onehot(g) || {ve, vr} !== 2'b01 || got !== exp) begin
                    errors++;
                    $display("FAIL rand_op r=%0d got rdy=%b ev=%b rsp=%h want %b 01 %h",
                             r, rdy, {ve, vr}, got, onehot(g), exp);
                end
            end
        end
        va = '0;
        drive_reqs();
    endtask

    initial begin
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin oa[i] = '0; ob[i] = '0; end
        drive_reqs();
        test_reset();
        test_add();
        test_sub();
        test_round_robin();
        test_backpressure();
        test_ptr();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
